digit_counter_mod: RTL and testbench



---
 rtl/watch_pkg.sv | 19 +
 rtl/button_debounce.sv | 81 ++++++++
 rtl/digit_counter_mod.sv | 82 ++++++++
 tb/tb_digit_counter_mod.sv | 163 ++++++++++++++++
 4 files changed

// File: rtl/watch_pkg.sv
// watch_pkg: shared types, constants and helpers for the watch time chain.
//   mode_e  : digit mode FSM states (RUN, SET)
//   deb_e   : button debounce FSM states (IDLE, WAIT_HI, PRESSED, WAIT_LO)
//   *_MOD   : default modulo values for the standard watch digits
//   clog2   : ceiling log2, usable in constant expressions
package watch_pkg;
    typedef enum logic {RUN, SET} mode_e;
    typedef enum logic [1:0] {IDLE, WAIT_HI, PRESSED, WAIT_LO} deb_e;
    localparam int SEC_MOD       = 60;
    localparam int MIN_UNITS_MOD = 10;
    localparam int MIN_TENS_MOD  = 6;
    localparam int HOUR_MOD      = 24;
    function automatic int clog2(input int v);
        int r;
        r = 0;
        while ((64'd1 << r) < 64'(v)) r = r + 1;
        return r;
    endfunction
endpackage

// File: rtl/button_debounce.sv
// button_debounce: 2-flop synchroniser, debounce FSM and optional auto-repeat.
//   clk_i           : system clock
//   rst_i           : asynchronous reset, active-high
//   button_i        : raw asynchronous push button, active-high
//   enable_repeat_i : allows auto-repeat pulses while the button is held
//   press_o         : one-cycle pulse per accepted press (plus repeats)
// Macro DIGCNT_AUTOREPEAT_EN adds a repeat pulse every REPEAT_CYC cycles
// while the button stays pressed and enable_repeat_i is high.
module button_debounce
    import watch_pkg::*;
#(
    parameter int DEBOUNCE_CYC = 4,
    parameter int REPEAT_CYC   = 8
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic button_i,
    input  logic enable_repeat_i,
    output logic press_o
);
    localparam int DW = clog2(DEBOUNCE_CYC + 1);
    localparam logic [DW-1:0] D_LAST = DW'(DEBOUNCE_CYC - 1);
    logic meta, sync, armed, accept;
    logic [1:0] fill;
    deb_e state, state_next;
    logic [DW-1:0] cnt, cnt_next;
    // armed only rises once the synchroniser holds real samples and the
    // button reads released, so a button held through reset never fires.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            meta  <= 1'b0;
            sync  <= 1'b0;
            fill  <= 2'b00;
            armed <= 1'b0;
            state <= IDLE;
            cnt   <= '0;
        end else begin
            meta  <= button_i;
            sync  <= meta;
            fill  <= {fill[0], 1'b1};
            armed <= armed | (fill[1] & ~sync);
            state <= state_next;
            cnt   <= cnt_next;
        end
    end
    // cnt counts stable samples including the one that left IDLE/PRESSED
    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        case (state)
            IDLE:    if (sync && armed) begin state_next = WAIT_HI; cnt_next = DW'(1); end
            WAIT_HI: if (!sync) state_next = IDLE;
                     else if (cnt >= D_LAST) state_next = PRESSED;
                     else cnt_next = cnt + 1'b1;
            PRESSED: if (!sync) begin state_next = WAIT_LO; cnt_next = DW'(1); end
            WAIT_LO: if (sync) state_next = PRESSED;
                     else if (cnt >= D_LAST) state_next = IDLE;
                     else cnt_next = cnt + 1'b1;
            default: state_next = IDLE;
        endcase
    end
    always_comb accept = (state == WAIT_HI) && sync && (cnt >= D_LAST);
`ifdef DIGCNT_AUTOREPEAT_EN
    localparam int RW = (clog2(REPEAT_CYC) < 1) ? 1 : clog2(REPEAT_CYC);
    localparam logic [RW-1:0] R_LAST = RW'(REPEAT_CYC - 1);
    logic [RW-1:0] rcnt;
    logic holding, rep;
    assign holding = (state == PRESSED) && enable_repeat_i;
    assign rep     = holding && (rcnt == R_LAST);
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) rcnt <= '0;
        else rcnt <= (holding && !rep) ? rcnt + 1'b1 : '0;
    end
    assign press_o = accept | rep;
`else
    localparam int unused_repeat_cyc = REPEAT_CYC;
    logic unused_enable;
    assign unused_enable = enable_repeat_i;
    assign press_o = accept;
`endif
endmodule

// File: rtl/digit_counter_mod.sv
// digit_counter_mod: modulo-MODULO watch digit with carry, half-rate toggle and set mode.
//   clk_i        : system clock
//   rst_i        : asynchronous reset, active-high
//   tick_i       : single-cycle count enable from upstream carry
//   clear_i      : synchronous clear to INIT
//   set_i        : level, high selects set mode
//   button_i     : raw push button, debounced internally
//   count_o      : current digit value
//   carry_o      : registered one-cycle pulse on wrap in RUN
//   half_o       : toggles at MODULO/2-1 and MODULO-1 on RUN ticks
//   set_active_o : high while the mode FSM is in SET
// Macro DIGCNT_AUTOREPEAT_EN enables button auto-repeat in SET mode.
module digit_counter_mod
    import watch_pkg::*;
#(
    parameter int WIDTH        = 4,
    parameter int MODULO       = 10,
    parameter int INIT         = 0,
    parameter int DEBOUNCE_CYC = 4,
    parameter int REPEAT_CYC   = 8
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             tick_i,
    input  logic             clear_i,
    input  logic             set_i,
    input  logic             button_i,
    output logic [WIDTH-1:0] count_o,
    output logic             carry_o,
    output logic             half_o,
    output logic             set_active_o
);
    localparam logic [WIDTH-1:0] MAX    = WIDTH'(MODULO - 1);
    localparam logic [WIDTH-1:0] MID    = WIDTH'(MODULO / 2 - 1);
    localparam logic [WIDTH-1:0] INIT_V = WIDTH'(INIT);
    mode_e mode, mode_next;
    logic in_set, press;
    logic [WIDTH-1:0] count_inc;
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            mode         <= RUN;
            set_active_o <= 1'b0;
        end else begin
            mode         <= mode_next;
            set_active_o <= (mode_next == SET);
        end
    end
    always_comb mode_next = set_i ? SET : RUN;
    always_comb in_set = (mode == SET);
    button_debounce #(
        .DEBOUNCE_CYC(DEBOUNCE_CYC),
        .REPEAT_CYC  (REPEAT_CYC)
    ) u_debounce (
        .clk_i          (clk_i),
        .rst_i          (rst_i),
        .button_i       (button_i),
        .enable_repeat_i(in_set),
        .press_o        (press)
    );
    // wrap is decided by comparison so MODULO < 2^WIDTH never overflows
    assign count_inc = (count_o == MAX) ? '0 : count_o + 1'b1;
    // presses outside SET are dropped; in SET ticks are dropped
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            count_o <= INIT_V;
            carry_o <= 1'b0;
            half_o  <= 1'b1;
        end else if (clear_i) begin
            count_o <= INIT_V;
            carry_o <= 1'b0;
        end else if (in_set) begin
            carry_o <= 1'b0;
            if (press) count_o <= count_inc;
        end else begin
            carry_o <= tick_i && (count_o == MAX);
            if (tick_i) begin
                count_o <= count_inc;
                if (count_o == MID || count_o == MAX) half_o <= ~half_o;
            end
        end
    end
endmodule

// File: tb/tb_digit_counter_mod.sv
// tb_digit_counter_mod: directed self-checking bench for digit_counter_mod.
module tb_digit_counter_mod;
`ifdef DIGCNT_AUTOREPEAT_EN
    localparam int EXP_HOLD = 4;
`else
    localparam int EXP_HOLD = 1;
`endif
    logic clk = 0, rst = 1, tick = 0, clear = 0, set = 0, button = 0;
    logic tick2 = 0, clear2 = 0, zero = 0;
    logic [3:0] count, count2;
    logic carry, half, set_active, carry2, half2, set_active2;
    int checks = 0, errors = 0, carry_seen = 0, base;

    digit_counter_mod dut (
        .clk_i(clk), .rst_i(rst), .tick_i(tick), .clear_i(clear), .set_i(set),
        .button_i(button), .count_o(count), .carry_o(carry), .half_o(half),
        .set_active_o(set_active)
    );
    digit_counter_mod #(.MODULO(6), .INIT(3)) dut2 (
        .clk_i(clk), .rst_i(rst), .tick_i(tick2), .clear_i(clear2), .set_i(zero),
        .button_i(zero), .count_o(count2), .carry_o(carry2), .half_o(half2),
        .set_active_o(set_active2)
    );

    always #5 clk = ~clk;
    always @(negedge clk) if (carry === 1'b1) carry_seen <= carry_seen + 1;

    task automatic step();
        @(posedge clk);
        #1;
    endtask
    task automatic hold(input int n);
        repeat (n) step();
    endtask
    task automatic press_cycle(input int lo);
        button = 1; hold(4);
        button = 0; hold(lo);
    endtask

    task automatic test_reset();
        rst = 1; step(); step();
        checks++; if (count !== 4'd0) begin errors++; $display("FAIL reset_count: got %0d want 0", count); end
        checks++; if (carry !== 1'b0) begin errors++; $display("FAIL reset_carry: got %b want 0", carry); end
        checks++; if (half !== 1'b1) begin errors++; $display("FAIL reset_half: got %b want 1", half); end
        checks++; if (set_active !== 1'b0) begin errors++; $display("FAIL reset_set_active: got %b want 0", set_active); end
        checks++; if (count2 !== 4'd3) begin errors++; $display("FAIL reset_count2: got %0d want 3", count2); end
        checks++; if (set_active2 !== 1'b0) begin errors++; $display("FAIL reset_set_active2: got %b want 0", set_active2); end
        rst = 0; hold(4);
        checks++; if (count !== 4'd0) begin errors++; $display("FAIL post_reset_count: got %0d want 0", count); end
    endtask

    task automatic test_count();
        logic exp_half;
        for (int i = 0; i < 10; i++) begin
            tick = 1; step();
            exp_half = (i < 4) ? 1'b1 : (i < 9) ? 1'b0 : 1'b1;
            checks++; if (count !== 4'((i + 1) % 10)) begin errors++; $display("FAIL count_run[%0d]: got %0d want %0d", i, count, (i + 1) % 10); end
            checks++; if (carry !== (i == 9)) begin errors++; $display("FAIL carry_run[%0d]: got %b want %b", i, carry, i == 9); end
            checks++; if (half !== exp_half) begin errors++; $display("FAIL half_run[%0d]: got %b want %b", i, half, exp_half); end
        end
        tick = 0; step();
        checks++; if (carry !== 1'b0) begin errors++; $display("FAIL carry_one_cycle: got %b want 0", carry); end
        checks++; if (count !== 4'd0) begin errors++; $display("FAIL count_idle: got %0d want 0", count); end
    endtask

    task automatic test_mod6();
        logic [3:0] exp;
        for (int i = 0; i < 3; i++) begin
            tick2 = 1; step();
            exp = (i == 0) ? 4'd4 : (i == 1) ? 4'd5 : 4'd0;
            checks++; if (count2 !== exp) begin errors++; $display("FAIL mod6_count[%0d]: got %0d want %0d", i, count2, exp); end
            checks++; if (carry2 !== (i == 2)) begin errors++; $display("FAIL mod6_carry[%0d]: got %b want %b", i, carry2, i == 2); end
        end
        tick2 = 0; step();
        checks++; if (carry2 !== 1'b0) begin errors++; $display("FAIL mod6_carry_end: got %b want 0", carry2); end
        checks++; if (half2 !== 1'b0) begin errors++; $display("FAIL mod6_half: got %b want 0", half2); end
        clear2 = 1; step(); clear2 = 0;
        checks++; if (count2 !== 4'd3) begin errors++; $display("FAIL mod6_clear: got %0d want 3", count2); end
        checks++; if (half2 !== 1'b0) begin errors++; $display("FAIL mod6_clear_half: got %b want 0", half2); end
    endtask

    task automatic test_set_press();
        set = 1; step();
        checks++; if (set_active !== 1'b1) begin errors++; $display("FAIL set_active_on: got %b want 1", set_active); end
        base = carry_seen;
        for (int r = 0; r < 3; r++) begin
            for (int k = 0; k < 8; k++) begin
                button = (k < 4);
                tick = (k % 2 == 0);
                step();
            end
            checks++; if (count !== 4'(r + 1)) begin errors++; $display("FAIL set_press[%0d]: got %0d want %0d", r, count, r + 1); end
        end
        tick = 0; button = 0; hold(2);
        checks++; if (carry_seen - base !== 0) begin errors++; $display("FAIL set_no_carry: got %0d pulses want 0", carry_seen - base); end
    endtask

    task automatic test_glitch();
        button = 1; hold(2); button = 0; hold(8);
        checks++; if (count !== 4'd3) begin errors++; $display("FAIL glitch: got %0d want 3", count); end
        set = 0; step();
        checks++; if (set_active !== 1'b0) begin errors++; $display("FAIL set_active_off: got %b want 0", set_active); end
        press_cycle(8);
        checks++; if (count !== 4'd3) begin errors++; $display("FAIL run_press: got %0d want 3", count); end
    endtask

    task automatic test_set_wrap();
        tick = 1; hold(6); tick = 0;
        checks++; if (count !== 4'd9) begin errors++; $display("FAIL wrap_pre_count: got %0d want 9", count); end
        checks++; if (half !== 1'b0) begin errors++; $display("FAIL wrap_pre_half: got %b want 0", half); end
        set = 1; step();
        base = carry_seen;
        press_cycle(8);
        checks++; if (count !== 4'd0) begin errors++; $display("FAIL set_wrap_count: got %0d want 0", count); end
        checks++; if (half !== 1'b0) begin errors++; $display("FAIL set_wrap_half: got %b want 0", half); end
        checks++; if (carry_seen - base !== 0) begin errors++; $display("FAIL set_wrap_carry: got %0d pulses want 0", carry_seen - base); end
        set = 0; step();
        tick = 1; step(); tick = 0;
        checks++; if (count !== 4'd1) begin errors++; $display("FAIL after_set_tick: got %0d want 1", count); end
        checks++; if (carry !== 1'b0) begin errors++; $display("FAIL after_set_carry: got %b want 0", carry); end
    endtask

    task automatic test_set_entry_tick();
        set = 1; tick = 1; step();
        checks++; if (count !== 4'd2) begin errors++; $display("FAIL entry_tick: got %0d want 2", count); end
        checks++; if (set_active !== 1'b1) begin errors++; $display("FAIL entry_set_active: got %b want 1", set_active); end
        step();
        checks++; if (count !== 4'd2) begin errors++; $display("FAIL set_tick_ignored: got %0d want 2", count); end
        tick = 0; set = 0; step();
    endtask

    task automatic test_reset_mid_hold();
        rst = 1; step(); rst = 0;
        set = 1; hold(4);
        button = 1; hold(36);
        checks++; if (count !== 4'(EXP_HOLD)) begin errors++; $display("FAIL hold_count: got %0d want %0d", count, EXP_HOLD); end
        rst = 1; #1;
        checks++; if (count !== 4'd0) begin errors++; $display("FAIL async_rst_count: got %0d want 0", count); end
        checks++; if (set_active !== 1'b0) begin errors++; $display("FAIL async_rst_set_active: got %b want 0", set_active); end
        checks++; if (half !== 1'b1) begin errors++; $display("FAIL async_rst_half: got %b want 1", half); end
        step(); rst = 0;
        hold(20);
        checks++; if (count !== 4'd0) begin errors++; $display("FAIL held_after_rst: got %0d want 0", count); end
        checks++; if (set_active !== 1'b1) begin errors++; $display("FAIL held_set_active: got %b want 1", set_active); end
        button = 0; hold(8);
        press_cycle(6);
        checks++; if (count !== 4'd1) begin errors++; $display("FAIL repress: got %0d want 1", count); end
        set = 0; step();
    endtask

    initial begin
        test_reset();
        test_count();
        test_mod6();
        test_set_press();
        test_glitch();
        test_set_wrap();
        test_set_entry_tick();
        test_reset_mid_hold();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
